// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter for instruction/data requests with watchdog
//
// Serialises the request unit's registered enables onto one RAM port. Data
// accesses win over instruction fetches. Hits are registered one-cycle pulses;
// after a hit the arbiter idles one cycle so the requester can drop its enable.
//
// Ports:
//   CLK, nRST              clock (rising edge), asynchronous active-low reset
//   iREN, iaddr            instruction read request and byte address
//   dREN, dWEN, daddr      data read/write request and byte address
//   dstore                 data write value
//   ihit, iload            instruction done pulse, fetched word (held)
//   dhit, dload            data done pulse, loaded word (held, reads only)
//   ram_ren, ram_wen       RAM strobes, decoded from state
//   ram_addr, ram_store    word-aligned RAM address, RAM write data
//   ram_load, ram_ready    RAM read data, RAM access-complete
//   error                  sticky watchdog error

module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              error
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t state, next_state;

    // Only the word address is kept; byte-offset bits never reach the RAM.
    logic [ADDR_W-3:0] word_addr;
    logic [DATA_W-1:0] store_q;
    logic              wen_q;
    logic [CNT_W-1:0]  wd_cnt;

    logic in_access;
    logic accept_d;
    logic accept_i;
    logic expire;

    logic unused_byte_bits;
    assign unused_byte_bits = &{1'b0, iaddr[1:0], daddr[1:0]};

    // The hit registers double as the post-hit dead cycle: no new request is
    // taken while either is still high.
    always_comb begin
        in_access = (state == DACC) || (state == IACC);
        accept_d  = (state == IDLE) && !ihit && !dhit && (dREN || dWEN);
        accept_i  = (state == IDLE) && !ihit && !dhit && !(dREN || dWEN) && iREN;
        expire    = in_access && !ram_ready && (wd_cnt == CNT_LAST);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        case (state)
            IDLE: begin
                if (accept_d) begin
                    next_state = DACC;
                end else if (accept_i) begin
                    next_state = IACC;
                end
            end
            DACC: begin
                ram_wen = wen_q;
                ram_ren = !wen_q;
                if (ram_ready) begin
                    next_state = IDLE;
                end else if (expire) begin
                    next_state = ERR;
                end
            end
            IACC: begin
                ram_ren = 1'b1;
                if (ram_ready) begin
                    next_state = IDLE;
                end else if (expire) begin
                    next_state = ERR;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign ram_addr  = {word_addr, 2'b00};
    assign ram_store = store_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            word_addr <= '0;
            store_q   <= '0;
            wen_q     <= 1'b0;
            wd_cnt    <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            iload     <= '0;
            dload     <= '0;
            error     <= 1'b0;
        end else begin
            ihit <= (state == IACC) && ram_ready;
            dhit <= (state == DACC) && ram_ready;

            if (accept_d) begin
                word_addr <= daddr[ADDR_W-1:2];
                store_q   <= dstore;
                wen_q     <= dWEN;
                wd_cnt    <= '0;
            end else if (accept_i) begin
                word_addr <= iaddr[ADDR_W-1:2];
                wen_q     <= 1'b0;
                wd_cnt    <= '0;
            end else if (in_access && !ram_ready) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end

            if ((state == IACC) && ram_ready) begin
                iload <= ram_load;
            end
            if ((state == DACC) && ram_ready && !wen_q) begin
                dload <= ram_load;
            end

            if (expire) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter

module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit;
    logic [31:0] iload, dload;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store, ram_load;
    logic        ram_ready;
    logic        error;

    int total = 0;
    int bad   = 0;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .error(error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ram_load = 0; ram_ready = 0;
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            iREN = 1'($urandom); dREN = 1'($urandom); dWEN = 1'($urandom);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
            ram_load = $urandom; ram_ready = 1'($urandom);
            @(negedge CLK);
            chk("rst_hits", {ihit, dhit, error}, 0);
            chk("rst_strobes", {ram_ren, ram_wen}, 0);
            chk("rst_loads", {iload, dload}, 0);
            chk("rst_ram", {ram_addr, ram_store}, 0);
        end
        idle_inputs();
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_strobes", {ram_ren, ram_wen, ihit, dhit}, 0);

        // 2: instruction fetch, ready on third IACC cycle
        iREN = 1; iaddr = 32'h104;
        @(negedge CLK);
        chk("if_ren_c1", ram_ren, 1);
        chk("if_addr", ram_addr, 32'h104);
        chk("if_ihit_early", ihit, 0);
        iREN = 0;
        @(negedge CLK);
        chk("if_ren_c2", ram_ren, 1);
        @(negedge CLK);
        chk("if_ren_c3", ram_ren, 1);
        ram_ready = 1; ram_load = 32'hDEADBEEF;
        @(negedge CLK);
        chk("if_ihit", ihit, 1);
        chk("if_iload", iload, 32'hDEADBEEF);
        chk("if_ren_off", ram_ren, 0);
        ram_ready = 0; ram_load = 0;
        @(negedge CLK);
        chk("if_ihit_pulse", ihit, 0);
        chk("if_iload_held", iload, 32'hDEADBEEF);

        // 3: simultaneous write and fetch, data first
        iREN = 1; iaddr = 32'h300;
        dWEN = 1; daddr = 32'h200; dstore = 32'h55AA55AA;
        @(negedge CLK);
        chk("wr_wen", {ram_wen, ram_ren}, 2'b10);
        chk("wr_store", ram_store, 32'h55AA55AA);
        chk("wr_addr", ram_addr, 32'h200);
        ram_ready = 1;
        @(negedge CLK);
        chk("wr_dhit", {dhit, ihit}, 2'b10);
        chk("wr_strobes_off", {ram_ren, ram_wen}, 0);
        dWEN = 0; ram_ready = 0;
        @(negedge CLK);
        chk("wr_dead_cycle", {ram_ren, ram_wen, dhit, ihit}, 0);
        @(negedge CLK);
        chk("wr_then_fetch", {ram_ren, ram_wen}, 2'b10);
        chk("wr_fetch_addr", ram_addr, 32'h300);
        ram_ready = 1; ram_load = 32'h12345678;
        @(negedge CLK);
        chk("wr_ihit", {ihit, dhit}, 2'b10);
        chk("wr_iload", iload, 32'h12345678);
        chk("wr_dload_untouched", dload, 0);
        iREN = 0; ram_ready = 0;
        @(negedge CLK);
        chk("wr_ihit_pulse", ihit, 0);

        // 6: unaligned read, enable dropped mid-access
        dREN = 1; daddr = 32'h107;
        @(negedge CLK);
        chk("rd_strobes", {ram_ren, ram_wen}, 2'b10);
        chk("rd_aligned", ram_addr, 32'h104);
        dREN = 0;
        @(negedge CLK);
        chk("rd_not_cancelled", ram_ren, 1);
        ram_ready = 1; ram_load = 32'hCAFEF00D;
        @(negedge CLK);
        chk("rd_dhit", {dhit, ihit}, 2'b10);
        chk("rd_dload", dload, 32'hCAFEF00D);
        @(negedge CLK);
        chk("idle_ready_ignored", {dhit, ihit, ram_ren}, 0);
        ram_ready = 0;

        // 5: reset during IACC aborts, then a fresh request completes
        iREN = 1; iaddr = 32'h40;
        @(negedge CLK);
        chk("ab_ren", ram_ren, 1);
        #2 nRST = 0;
        #1;
        chk("ab_strobes_now", {ram_ren, ram_wen, ihit}, 0);
        iREN = 0;
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        chk("ab_no_ihit", {ihit, ram_ren}, 0);
        iREN = 1; iaddr = 32'h80;
        @(negedge CLK);
        chk("ab_fresh_addr", {ram_ren, ram_addr}, {1'b1, 32'h80});
        iREN = 0; ram_ready = 1; ram_load = 32'hA5A5A5A5;
        @(negedge CLK);
        chk("ab_fresh_ihit", {ihit, iload}, {1'b1, 32'hA5A5A5A5});
        ram_ready = 0;
        @(negedge CLK);

        // 4: watchdog, TIMEOUT=8
        dREN = 1; daddr = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            chk($sformatf("wd_ren_c%0d", c), {ram_ren, error}, 2'b10);
        end
        @(negedge CLK);
        chk("wd_error", error, 1);
        chk("wd_strobes_off", {ram_ren, ram_wen, dhit}, 0);
        iREN = 1; ram_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("wd_err_terminal", {error, ihit, dhit, ram_ren, ram_wen}, 5'b10000);
        end
        idle_inputs();
        nRST = 0;
        #1;
        chk("wd_err_cleared", error, 0);
        @(negedge CLK);
        nRST = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
